// File: rtl/pb_stream_pkg.sv
// Shared constants, pointer-width helper and word type for the pb_stream buffer.
package pb_stream_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // A depth of 1 would give a zero-width pointer, so clamp to one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [DEFAULT_DATA_W-1:0] stream_word_t;

endpackage

// File: rtl/pb_stream_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module pb_stream_ram
  import pb_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = ptr_width(DEPTH)
) (
  input  logic              ck1,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; the pointers alone define what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge ck1) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pb_stream_fifo.sv
// Synchronous valid/ready FIFO: pointers, fill count and handshake around pb_stream_ram.
module pb_stream_fifo
  import pb_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                   ck1,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready = !full (no pass-through when full), out_valid = !empty (no
  // bypass when empty); neither ready depends on the partner's valid.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge ck1) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  pb_stream_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_ram (
    .ck1   (ck1),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_pb_stream_fifo.sv
// Self-checking bench for pb_stream_fifo: directed vector table, corner sequences, random vs queue model.
module tb_pb_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  // clock / reset
  logic              ck1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  logic              full;
  logic              empty;

  always #5 ck1 = ~ck1;

  pb_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ck1       (ck1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    int                exp_count;
    logic [DATA_W-1:0] exp_head;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    chk({tag, ".count"},     int'(count),     exp_q.size());
    chk({tag, ".empty"},     int'(empty),     int'(exp_q.size() == 0));
    chk({tag, ".full"},      int'(full),      int'(exp_q.size() == DEPTH));
    chk({tag, ".in_ready"},  int'(in_ready),  int'(exp_q.size() != DEPTH));
    chk({tag, ".out_valid"}, int'(out_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ".out_data"}, int'(out_data), int'(exp_q[0]));
  endtask

  // Driver: one clock with the given inputs; the model is updated from the rules
  // (refused push when full, no pop when empty, reset wins) and then checked.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic rst, input string tag);
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    rst_n     = rst;
    do_push = rst && iv && (exp_q.size() < DEPTH);
    do_pop  = rst && ordy && (exp_q.size() > 0);
    @(posedge ck1); #1;
    if (!rst) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    check_model(tag);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    rst_n     = 1'b1;
    @(posedge ck1); #1;
    chk({tag, ".count"},     int'(count),     v.exp_count);
    chk({tag, ".empty"},     int'(empty),     int'(v.exp_count == 0));
    chk({tag, ".full"},      int'(full),      int'(v.exp_count == DEPTH));
    chk({tag, ".in_ready"},  int'(in_ready),  int'(v.exp_count != DEPTH));
    chk({tag, ".out_valid"}, int'(out_valid), int'(v.exp_count != 0));
    if (v.exp_count != 0) chk({tag, ".out_data"}, int'(out_data), int'(v.exp_head));
  endtask

  task automatic add_vec(input logic iv, input int d, input logic ordy,
                         input int cnt, input int head);
    vec_t v;
    v.iv = iv; v.d = DATA_W'(d); v.ordy = ordy;
    v.exp_count = cnt; v.exp_head = DATA_W'(head);
    vecs.push_back(v);
  endtask

  initial begin
    logic              cur_v;
    logic [DATA_W-1:0] cur_d;
    int                push_pct, pop_pct;

    // Reset held for 50 cycles, then released.
    for (int i = 0; i < 50; i++) cycle(1'b0, '0, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    #1;
    check_model("reset_release");

    // Directed vector table: single word, fill, refused 17th, wrap-around drain.
    add_vec(1, 'hA5, 0, 1, 'hA5);
    add_vec(0, 0,    1, 0, 0);
    for (int i = 0; i < 16; i++) add_vec(1, i, 0, i + 1, 'h00);
    add_vec(1, 'hFF, 0, 16, 'h00);
    for (int i = 0; i < 8; i++)  add_vec(0, 0, 1, 15 - i, i + 1);
    for (int i = 0; i < 8; i++)  add_vec(1, 'h10 + i, 0, 9 + i, 'h08);
    for (int i = 0; i < 16; i++) add_vec(0, 0, 1, 15 - i, 9 + i);
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Simultaneous push/pop at count 5.
    exp_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'('h40 + i), 1'b0, 1'b1, "fill5");
    cycle(1'b1, 8'h55, 1'b1, 1'b1, "simul5");
    chk("simul5.count_const", int'(count), 5);
    chk("simul5.head_const",  int'(out_data), 'h41);

    // At full with both valid and ready: only the pop happens.
    while (exp_q.size() < DEPTH) cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b1, "fill16");
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, "full_both");
    chk("full_both.count_const", int'(count), 15);

    // Reset mid-operation with 7 words stored, while a push and pop are offered.
    cycle(1'b0, '0, 1'b0, 1'b0, "pre_rst");
    for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'('h70 + i), 1'b0, 1'b1, "fill7");
    chk("fill7.count_const", int'(count), 7);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, "mid_rst");
    chk("mid_rst.count_const", int'(count), 0);
    chk("mid_rst.empty_const", int'(empty), 1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b1, "after_rst");
    chk("after_rst.head_const", int'(out_data), 'h3C);
    cycle(1'b0, '0, 1'b1, 1'b1, "after_rst_pop");

    // Random traffic in alternating fill-heavy / drain-heavy windows.
    cur_v = 1'b0;
    cur_d = '0;
    for (int w = 0; w < 24; w++) begin
      push_pct = (w % 2 == 0) ? 85 : 30;
      pop_pct  = (w % 2 == 0) ? 30 : 85;
      for (int c = 0; c < 60; c++) begin
        bit accepted;
        if (!cur_v) begin
          cur_v = ($urandom_range(0, 99) < push_pct);
          cur_d = DATA_W'($urandom_range(0, 255));
        end
        accepted = cur_v && (exp_q.size() < DEPTH);
        if ($urandom_range(0, 299) == 0) begin
          cycle(cur_v, cur_d, 1'b1, 1'b0, "rand_rst");
          cur_v = 1'b0;
        end else begin
          cycle(cur_v, cur_d, ($urandom_range(0, 99) < pop_pct), 1'b1, "rand");
          if (accepted) cur_v = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
